// File: rtl/id_tx_seq_ctrl_if.sv
// rtl/id_tx_seq_ctrl_if.sv - control/strobe bundle between the ID transmit sequencer and its datapath
interface id_tx_seq_ctrl_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] empty;
    logic [NCH-1:0] empty_prev;
    logic           start_test;
    logic           end_test;
    logic           end_test_global;
    logic           abort;
    logic [NCH-1:0] load;
    logic [NCH-1:0] clear;
    logic [NCH-1:0] reset_id;
    logic [NCH-1:0] clear_prev;
    logic           restart_col_select;
    logic [1:0]     state;
    logic [NCH-1:0] ovf;

    modport master (
        output empty, empty_prev, start_test, end_test, end_test_global, abort,
        input  load, clear, reset_id, clear_prev, restart_col_select, state, ovf
    );

    modport slave (
        input  empty, empty_prev, start_test, end_test, end_test_global, abort,
        output load, clear, reset_id, clear_prev, restart_col_select, state, ovf
    );
endinterface

// File: rtl/id_tx_seq_ctrl.sv
// rtl/id_tx_seq_ctrl.sv - multi-channel ID transmit sequencer (INIT/BIST/ESPERA/RUN) with per-channel strobe counters
module id_tx_seq_ctrl #(
    parameter int NCH          = 4,
    parameter int CW           = 4,
    parameter int START_TX     = 4,
    parameter int STOP_TX      = 14,
    parameter int STOP_TX_PREV = 10,
    parameter bit BIST_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    id_tx_seq_ctrl_if.slave      bus
);
    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_BIST   = 2'd1;
    localparam logic [1:0] ST_ESPERA = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] LOAD_AT    = CW'(START_TX);
    localparam logic [CW-1:0] CLEAR_AT   = CW'(STOP_TX - 1);
    localparam logic [CW-1:0] RESET_AT   = CW'(STOP_TX);
    localparam logic [CW-1:0] CLR_PRV_AT = CW'(STOP_TX_PREV);

    logic [1:0]              state_q, state_d;
    logic [NCH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0][CW-1:0]  cntp_q, cntp_d;
    logic [NCH-1:0]          ovf_q, ovf_d;
    logic                    active;

    assign active = (state_q == ST_BIST) || (state_q == ST_RUN);

    // abort outranks every forward transition
    always_comb begin
        state_d = state_q;
        if (bus.abort && state_q != ST_INIT) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:   if (bus.start_test)      state_d = BIST_EN ? ST_BIST : ST_RUN;
                ST_BIST:   if (bus.end_test)        state_d = ST_ESPERA;
                ST_ESPERA: if (bus.end_test_global) state_d = ST_RUN;
                default:                            state_d = state_q;
            endcase
        end
    end

    // counters saturate instead of wrapping so a stuck channel never re-fires its strobes
    always_comb begin
        cnt_d  = cnt_q;
        cntp_d = cntp_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            if (bus.empty[i])              cnt_d[i] = '0;
            else if (cnt_q[i] != CNT_MAX)  cnt_d[i] = cnt_q[i] + 1'b1;

            if (bus.empty_prev[i])         cntp_d[i] = '0;
            else if (cntp_q[i] != CNT_MAX) cntp_d[i] = cntp_q[i] + 1'b1;

            if (state_q == ST_INIT) begin
                ovf_d[i] = 1'b0;
            end else if (active && ((cnt_q[i] == CNT_MAX && !bus.empty[i]) ||
                                    (cntp_q[i] == CNT_MAX && !bus.empty_prev[i]))) begin
                ovf_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            cntp_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cntp_q  <= cntp_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        bus.load               = '0;
        bus.clear              = '1;
        bus.reset_id           = '0;
        bus.clear_prev         = '1;
        bus.restart_col_select = 1'b1;
        if (active) begin
            bus.restart_col_select = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                bus.load[i]       = (cnt_q[i] == LOAD_AT);
                bus.clear[i]      = (cnt_q[i] == CLEAR_AT);
                bus.reset_id[i]   = (cnt_q[i] == RESET_AT);
                bus.clear_prev[i] = (cntp_q[i] == CLR_PRV_AT);
            end
        end
    end

    // ovf must read 0 on the very first INIT cycle, before ovf_q has been cleared
    assign bus.ovf   = (state_q == ST_INIT) ? '0 : ovf_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_id_tx_seq_ctrl.sv
// tb/tb_id_tx_seq_ctrl.sv - randomized model-checked bench for id_tx_seq_ctrl (BIST_EN=1 and BIST_EN=0 instances)
module tb_id_tx_seq_ctrl;
    localparam int NCH = 4;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic reset;
    logic [NCH-1:0] empty, empty_prev;
    logic start_test, end_test, end_test_global, abort;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_tx_seq_ctrl_if #(.NCH(NCH)) if_a ();
    id_tx_seq_ctrl_if #(.NCH(NCH)) if_b ();

    assign if_a.empty = empty;            assign if_b.empty = empty;
    assign if_a.empty_prev = empty_prev;  assign if_b.empty_prev = empty_prev;
    assign if_a.start_test = start_test;  assign if_b.start_test = start_test;
    assign if_a.end_test = end_test;      assign if_b.end_test = end_test;
    assign if_a.end_test_global = end_test_global;
    assign if_b.end_test_global = end_test_global;
    assign if_a.abort = abort;            assign if_b.abort = abort;

    id_tx_seq_ctrl #(.BIST_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    id_tx_seq_ctrl #(.BIST_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: plain integer counts and state numbers, one state/ovf per instance
    int  mc [NCH];
    int  mp [NCH];
    int  ms [2];
    bit  mo [2][NCH];
    bit  mvalid = 1'b0;

    always @(posedge clk) begin
        int s, ns;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                mc[i] <= 0; mp[i] <= 0; mo[0][i] <= 1'b0; mo[1][i] <= 1'b0;
            end
            ms[0] <= 0; ms[1] <= 0;
            mvalid <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                s = ms[k];
                for (int i = 0; i < NCH; i++) begin
                    if (s == 0) mo[k][i] <= 1'b0;
                    else if ((s == 1 || s == 3) &&
                             ((mc[i] == MAXC && !empty[i]) || (mp[i] == MAXC && !empty_prev[i])))
                        mo[k][i] <= 1'b1;
                end
                ns = s;
                if (abort && s != 0) ns = 0;
                else if (s == 0 && start_test) ns = (k == 0) ? 1 : 3;
                else if (s == 1 && end_test) ns = 2;
                else if (s == 2 && end_test_global) ns = 3;
                ms[k] <= ns;
            end
            for (int i = 0; i < NCH; i++) begin
                mc[i] <= empty[i] ? 0 : (mc[i] < MAXC ? mc[i] + 1 : MAXC);
                mp[i] <= empty_prev[i] ? 0 : (mp[i] < MAXC ? mp[i] + 1 : MAXC);
            end
        end
    end

    task automatic compare_inst(input int k, input logic [1:0] st, input logic [NCH-1:0] ld,
                                input logic [NCH-1:0] cl, input logic [NCH-1:0] rid,
                                input logic [NCH-1:0] clp, input logic rcs, input logic [NCH-1:0] ov);
        logic [NCH-1:0] eld, ecl, erid, eclp, eov;
        bit act;
        act = (ms[k] == 1 || ms[k] == 3);
        for (int i = 0; i < NCH; i++) begin
            eld[i]  = act && mc[i] == 4;
            ecl[i]  = act ? (mc[i] == 13) : 1'b1;
            erid[i] = act && mc[i] == 14;
            eclp[i] = act ? (mp[i] == 10) : 1'b1;
            eov[i]  = (ms[k] != 0) && mo[k][i];
        end
        check($sformatf("state[%0d]", k), 32'(st), 32'(ms[k]));
        check($sformatf("load[%0d]", k), 32'(ld), 32'(eld));
        check($sformatf("clear[%0d]", k), 32'(cl), 32'(ecl));
        check($sformatf("reset_id[%0d]", k), 32'(rid), 32'(erid));
        check($sformatf("clear_prev[%0d]", k), 32'(clp), 32'(eclp));
        check($sformatf("restart_col[%0d]", k), 32'(rcs), 32'(!act));
        check($sformatf("ovf[%0d]", k), 32'(ov), 32'(eov));
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            compare_inst(0, if_a.state, if_a.load, if_a.clear, if_a.reset_id, if_a.clear_prev,
                         if_a.restart_col_select, if_a.ovf);
            compare_inst(1, if_b.state, if_b.load, if_b.clear, if_b.reset_id, if_b.clear_prev,
                         if_b.restart_col_select, if_b.ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int f_ld, f_cl, f_rid, f_clp, n_ld, n_cl, n_rid;
        reset = 1'b1; empty = '1; empty_prev = '1;
        start_test = 1'b0; end_test = 1'b0; end_test_global = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(if_a.state), 32'd0);
        check("rst_clear", 32'(if_a.clear), 32'hF);
        check("rst_restart", 32'(if_a.restart_col_select), 32'd1);
        check("rst_load", 32'(if_a.load), 32'd0);

        // Directed: one start pulse, then watch channel 0 strobes by cycle number (== count)
        reset = 1'b0; empty = '0; empty_prev = '0; start_test = 1'b1;
        tick();
        start_test = 1'b0;
        check("bist_entry", 32'(if_a.state), 32'd1);
        check("nobist_entry", 32'(if_b.state), 32'd3);
        f_ld = 0; f_cl = 0; f_rid = 0; f_clp = 0; n_ld = 0; n_cl = 0; n_rid = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc > 1) tick();
            if (if_a.load[0])       begin n_ld++;  if (f_ld == 0)  f_ld = cyc;  end
            if (if_a.clear[0])      begin n_cl++;  if (f_cl == 0)  f_cl = cyc;  end
            if (if_a.reset_id[0])   begin n_rid++; if (f_rid == 0) f_rid = cyc; end
            if (if_a.clear_prev[1] && f_clp == 0) f_clp = cyc;
            if (cyc == 15) check("ovf_before_sat", 32'(if_a.ovf[0]), 32'd0);
            if (cyc == 16) check("ovf_after_sat", 32'(if_a.ovf[0]), 32'd1);
        end
        check("load_cycle", 32'(f_ld), 32'd4);
        check("load_once", 32'(n_ld), 32'd1);
        check("clear_cycle", 32'(f_cl), 32'd13);
        check("clear_once", 32'(n_cl), 32'd1);
        check("reset_id_cycle", 32'(f_rid), 32'd14);
        check("reset_id_once", 32'(n_rid), 32'd1);
        check("clear_prev_cycle", 32'(f_clp), 32'd10);

        end_test = 1'b1; tick(); end_test = 1'b0;
        check("espera_state", 32'(if_a.state), 32'd2);
        check("espera_clear", 32'(if_a.clear), 32'hF);
        check("espera_restart", 32'(if_a.restart_col_select), 32'd1);
        end_test_global = 1'b1; tick(); end_test_global = 1'b0;
        check("run_state", 32'(if_a.state), 32'd3);
        check("run_ovf_held", 32'(if_a.ovf), 32'hF);
        abort = 1'b1; end_test_global = 1'b1; tick(); abort = 1'b0; end_test_global = 1'b0;
        check("abort_state", 32'(if_a.state), 32'd0);
        check("abort_ovf", 32'(if_a.ovf), 32'd0);

        // Reset mid-RUN with nonzero counts
        empty = '1; tick(); empty = '0;
        start_test = 1'b1; tick(); start_test = 1'b0;
        repeat (5) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrun_rst_state", 32'(if_a.state), 32'd0);
        check("midrun_rst_clear", 32'(if_a.clear), 32'hF);
        check("midrun_rst_load", 32'(if_a.load), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NCH; i++) begin
                empty[i]      = ($urandom_range(0, 11) == 0);
                empty_prev[i] = ($urandom_range(0, 11) == 0);
            end
            start_test      = ($urandom_range(0, 3) == 0);
            end_test        = ($urandom_range(0, 7) == 0);
            end_test_global = ($urandom_range(0, 7) == 0);
            abort           = ($urandom_range(0, 24) == 0);
            tick();
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
